mem_stall_ctrl: RTL
===================

Name: mem_stall_ctrl

Overview:
- Parametrised memory-access stall generator between riscv_core and data_mem.
- Holds the core's stall_i for a configurable, per-direction number of cycles per data-memory request, and optionally waits on a memory ready handshake.
- Replaces the fixed one-cycle stall flop at the top level.
- Also provides a saturating stall-cycle performance counter.

Parameters:
- RD_LAT, 1, stall cycles for a read (mem_we_i=0); legal 0..15.
- WR_LAT, 1, stall cycles for a write (mem_we_i=1); legal 0..15.
- CNT_W, 4, width of the latency down-counter; must hold max(RD_LAT, WR_LAT).
- TIMEOUT, 255, ready-wait limit in cycles; used only with the optional feature.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_ni, input, 1, reset; asynchronous, active-low.
- mem_req_i, input, 1, data-memory request from the core.
- mem_we_i, input, 1, write enable from the core; selects RD_LAT or WR_LAT.
- mem_ready_i, input, 1, memory ready; tie to 1 for fixed-latency memory.
- mem_req_o, output, 1, request forwarded to data_mem.
- stall_o, output, 1, to core stall_i.
- busy_o, output, 1, high while in WAIT.
- stall_cnt_o, output, 32, total cycles with stall_o=1.
- timeout_o, output, 1, sticky timeout flag.

Behaviour:
- Reset (rst_ni=0, asynchronous) forces:
  - state=IDLE, cnt=0;
  - stall_cnt_o=0, timeout_o=0;
  - stall_o, mem_req_o and busy_o all 0.
  - This applies mid-access too: the access is abandoned, with no release cycle.
- L = mem_we_i ? WR_LAT : RD_LAT, sampled in IDLE only.
- States: IDLE, WAIT.
- IDLE:
  - mem_req_i=0: all outputs low.
  - mem_req_i=1, L=0, mem_ready_i=1: zero-wait access. stall_o=0, state stays IDLE.
  - mem_req_i=1, otherwise: stall_o=1, cnt<=(L=0 ? 0 : L-1), state<=WAIT.
- WAIT:
  - cnt!=0: stall_o=1, cnt<=cnt-1.
  - cnt=0, mem_ready_i=0: stall_o=1, hold.
  - cnt=0, mem_ready_i=1: release cycle. stall_o=0, state<=IDLE.
- Combinational outputs:
  - stall_o = (IDLE & mem_req_i & !(L=0 & mem_ready_i)) | (WAIT & (cnt!=0 | !mem_ready_i)).
  - mem_req_o = (IDLE & mem_req_i) | WAIT.
  - busy_o = WAIT.
- Latency: with ready held high, a request first seen in IDLE at cycle T gets stall_o=1 for exactly L cycles (T..T+L-1). stall_o=0 at T+L.
- Back-to-back requests:
  - The release cycle always returns to IDLE.
  - A request present in the following IDLE cycle starts a new access.
  - With L>0, stall_o pulses L high then 1 low per access. Example: for L=1, 1,0,1,0…
- mem_req_i or mem_we_i changing during WAIT is a protocol violation. It is ignored: the latency already loaded completes.
- stall_cnt_o increments on each cycle with stall_o=1 and saturates at 32'hFFFF_FFFF (no wrap).
- Parameter check: RD_LAT or WR_LAT > 2**CNT_W-1 must trigger an elaboration-time $error.

Optional Feature:
- Macro MEM_STALL_TIMEOUT_EN.
- Defined:
  - A ready-wait counter counts consecutive WAIT cycles with cnt=0 and mem_ready_i=0.
  - When it reaches TIMEOUT: force release that cycle (stall_o=0, state<=IDLE) and set timeout_o=1.
  - timeout_o stays set until reset.
  - The counter clears on entry to WAIT.
- Undefined:
  - No counter logic is generated.
  - timeout_o is tied to 0.
  - WAIT holds indefinitely on mem_ready_i=0.

Test Plan:
1. RD_LAT=1, ready=1, single read request at cycle 5 -> stall_o high at cycle 5 only, low at 6; mem_req_o high at 5 and 6; stall_cnt_o=1.
2. RD_LAT=3, WR_LAT=0, read then write held back-to-back -> read: stall_o 1,1,1,0. Write: stall_o=0 with no WAIT entry. stall_cnt_o=3.
3. RD_LAT=2, mem_ready_i low for 4 cycles after the count expires -> stall_o high for 2+4=6 cycles, release on the first cycle ready=1, then IDLE.
4. rst_ni pulsed low asynchronously mid-WAIT (cnt=2) -> stall_o, busy_o and mem_req_o drop immediately; stall_cnt_o=0; the next request restarts full latency.
5. MEM_STALL_TIMEOUT_EN, TIMEOUT=8, mem_ready_i stuck 0, RD_LAT=1 -> forced release after 8 ready-wait cycles; timeout_o=1 stays set through later accesses until reset. Without the macro: stall_o stays high and timeout_o=0.
6. stall_cnt_o preloaded via force to 32'hFFFF_FFFE, then 3 stall cycles -> reads 32'hFFFF_FFFF, with no wrap.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl
//   Memory-access stall generator sitting between riscv_core and data_mem.
//   Each data-memory request holds the core's stall_i for a per-direction
//   number of cycles (RD_LAT for reads, WR_LAT for writes). Once that count
//   has run out, the access still waits for mem_ready_i. A release cycle
//   (stall_o=0) then returns the controller to IDLE. A saturating 32-bit
//   counter records every cycle with stall_o=1.
//
//   Optional feature: define MEM_STALL_TIMEOUT_EN to add a ready-wait
//   watchdog. If mem_ready_i stays low for TIMEOUT consecutive cycles after
//   the latency has expired, the access is force-released and the sticky
//   timeout_o flag is raised. Without the macro, timeout_o is tied to 0 and
//   WAIT holds for as long as mem_ready_i stays low.
//
// Parameters
//   RD_LAT  - stall cycles for a read  (0..2**CNT_W-1)
//   WR_LAT  - stall cycles for a write (0..2**CNT_W-1)
//   CNT_W   - width of the latency down-counter
//   TIMEOUT - ready-wait limit in cycles (MEM_STALL_TIMEOUT_EN only)
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   mem_req_i    in   data-memory request from the core
//   mem_we_i     in   write enable from the core (selects WR_LAT/RD_LAT)
//   mem_ready_i  in   memory ready (tie high for fixed-latency memory)
//   mem_req_o    out  request forwarded to data_mem
//   stall_o      out  to core stall_i
//   busy_o       out  high while in WAIT
//   stall_cnt_o  out  saturating count of cycles with stall_o=1
//   timeout_o    out  sticky ready-wait timeout flag
module mem_stall_ctrl #(
  parameter int RD_LAT  = 1,
  parameter int WR_LAT  = 1,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] stall_cnt_o,
  output logic        timeout_o
);

  if ((RD_LAT < 0) || (RD_LAT > (2**CNT_W) - 1) ||
      (WR_LAT < 0) || (WR_LAT > (2**CNT_W) - 1)) begin : g_lat_chk
    $error("mem_stall_ctrl: RD_LAT/WR_LAT must fit in CNT_W bits");
  end

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("mem_stall_ctrl: TIMEOUT must be at least 1");
  end

  localparam logic [CNT_W-1:0] RD_L = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_L = CNT_W'(WR_LAT);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lat;
  logic             stall_c, req_c, busy_c;
  logic             force_rel;
  logic [31:0]      stall_cnt_q;

  // Latency is only consulted in IDLE; in WAIT the loaded count runs out
  // regardless of what mem_req_i/mem_we_i do.
  assign lat = mem_we_i ? WR_L : RD_L;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    req_c   = 1'b0;
    busy_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          req_c = 1'b1;
          // Zero latency with memory already ready completes in place.
          if (!((lat == '0) && mem_ready_i)) begin
            stall_c = 1'b1;
            cnt_d   = (lat == '0) ? '0 : lat - CNT_W'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req_c  = 1'b1;
        busy_c = 1'b1;
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else if (mem_ready_i || force_rel) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are gated by reset so an abandoned access drops its request
  // and stall immediately, even while the core still drives mem_req_i.
  assign stall_o   = rst_ni & stall_c;
  assign mem_req_o = rst_ni & req_c;
  assign busy_o    = rst_ni & busy_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

`ifdef MEM_STALL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] rw_cnt_q;
  logic            timeout_q;
  logic            ready_wait;

  // A ready-wait cycle: latency exhausted, memory still not ready.
  assign ready_wait = (state_q == WAIT) && (cnt_q == '0) && !mem_ready_i;
  // TIMEOUT ready-wait cycles have already stalled; release on the next.
  assign force_rel  = ready_wait && (rw_cnt_q == TO_W'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rw_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && (state_d == WAIT)) begin
        rw_cnt_q <= '0;
      end else if (ready_wait && !force_rel) begin
        rw_cnt_q <= rw_cnt_q + TO_W'(1);
      end
      if (force_rel) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule
